// File: rtl/sa_ctrl_pkg.sv
// Shared types and mask helpers for the parametrised systolic-array controller.
// Helpers return a fixed MAX_N-sized vector; callers slice to their own N.
package sa_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_N = 32;

  // Bit r*n+c is set when PE(r,c) lies on anti-diagonal k counted from PE(n-1,n-1).
  function automatic logic [MAX_N*MAX_N-1:0] antidiag_mask(input int n, input int k);
    logic [MAX_N*MAX_N-1:0] m;
    m = '0;
    for (int r = 0; r < MAX_N; r++) begin
      for (int c = 0; c < MAX_N; c++) begin
        if (r < n && c < n && ((n - 1 - r) + (n - 1 - c)) == k) begin
          m[r*n+c] = 1'b1;
        end else begin
          m = m;
        end
      end
    end
    return m;
  endfunction

  // Row (2n-2-k) is selected while k sits in the writing window n-1..2n-2.
  function automatic logic [MAX_N-1:0] row_onehot(input int n, input int k);
    logic [MAX_N-1:0] v;
    v = '0;
    if (k >= n - 1 && k <= 2 * n - 2) begin
      v[2*n-2-k] = 1'b1;
    end else begin
      v = '0;
    end
    return v;
  endfunction

endpackage

// File: rtl/sa_drain_seq.sv
// Drain sequencer: walks k = 0..2N-1, emits clc mask, row select and output writes.
// A write is taken on a cycle with wr_en and out_ready both high; otherwise the step is held.
module sa_drain_seq
  import sa_ctrl_pkg::*;
#(
  parameter int N      = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_drain,
  input  logic              load_sa,
  input  logic              out_ready,
  input  logic [ADDR_W-1:0] out_base,
  output logic              drain_done,
  output logic              sa_en,
  output logic [N*N-1:0]    sa_clc,
  output logic [N-1:0]      row_out_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int KW = $clog2(2 * N);
  localparam logic [KW-1:0] K_LAST     = KW'(2 * N - 1);
  localparam logic [KW-1:0] K_FIRST_WR = KW'(N - 1);
  localparam logic [KW-1:0] K_LAST_WR  = KW'(2 * N - 2);

  logic                     active_r;
  logic [KW-1:0]            k_r;
  logic                     act_nxt;
  logic [KW-1:0]            k_nxt;
  logic                     fresh_s;
  logic                     hold_s;
  logic                     writing_s;
  logic [MAX_N*MAX_N-1:0]   mask_full_s;
  logic [MAX_N-1:0]         row_full_s;
  logic                     unused_s;
  logic [N*N-1:0]           clc_nxt;
  logic [N-1:0]             row_nxt;
  logic                     wr_nxt;
  logic                     sa_nxt;
  logic [ADDR_W-1:0]        addr_nxt;

  assign writing_s  = active_r && (k_r >= K_FIRST_WR) && (k_r <= K_LAST_WR);
  assign drain_done = active_r && (k_r == K_LAST);

  // Step control: a writing step stays put until its write is taken.
  always_comb begin
    act_nxt = active_r;
    k_nxt   = k_r;
    fresh_s = 1'b0;
    hold_s  = 1'b0;
    if (start_drain) begin
      act_nxt = 1'b1;
      k_nxt   = '0;
      fresh_s = 1'b1;
    end else if (!active_r) begin
      act_nxt = 1'b0;
    end else if (k_r == K_LAST) begin
      act_nxt = 1'b0;
      k_nxt   = '0;
    end else if (writing_s && !(wr_en && out_ready)) begin
      hold_s = 1'b1;
    end else begin
      k_nxt   = k_r + KW'(1);
      fresh_s = 1'b1;
    end
  end

  // Output values for the next cycle; a held step keeps its payload but stops the array.
  always_comb begin
    mask_full_s = antidiag_mask(N, int'(k_nxt));
    row_full_s  = row_onehot(N, int'(k_nxt));
    unused_s    = ^mask_full_s ^ ^row_full_s;
    clc_nxt     = '0;
    row_nxt     = '0;
    wr_nxt      = 1'b0;
    sa_nxt      = 1'b0;
    addr_nxt    = '0;
    if (fresh_s) begin
      clc_nxt  = mask_full_s[N*N-1:0];
      row_nxt  = row_full_s[N-1:0];
      wr_nxt   = (k_nxt >= K_FIRST_WR) && (k_nxt <= K_LAST_WR);
      sa_nxt   = (k_nxt != K_LAST);
      addr_nxt = wr_nxt ? (out_base + ADDR_W'(k_nxt - K_FIRST_WR)) : '0;
    end else if (hold_s) begin
      clc_nxt  = sa_clc;
      row_nxt  = row_out_valid;
      wr_nxt   = out_ready;
      sa_nxt   = 1'b0;
      addr_nxt = wr_addr;
    end else begin
      clc_nxt = '0;
    end
  end

  // Drain state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r      <= 1'b0;
      k_r           <= '0;
      sa_clc        <= '0;
      row_out_valid <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      sa_en         <= 1'b0;
    end else begin
      active_r      <= act_nxt;
      k_r           <= k_nxt;
      sa_clc        <= clc_nxt;
      row_out_valid <= row_nxt;
      wr_en         <= wr_nxt;
      wr_addr       <= addr_nxt;
      sa_en         <= sa_nxt | load_sa;
    end
  end

endmodule

// File: rtl/sa_ctrl_param.sv
// Tile controller for an N x N systolic array: accept, load input words, drain, report done.
module sa_ctrl_param
  import sa_ctrl_pkg::*;
#(
  parameter int N      = 8,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] in_start_addr,
  input  logic [LEN_W-1:0]  in_len,
  input  logic [ADDR_W-1:0] out_start_addr,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              sa_en,
  output logic [N*N-1:0]    sa_clc,
  output logic [N-1:0]      row_out_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  state_t             state_r;
  state_t             state_nxt;
  logic [LEN_W-1:0]   rem_r;
  logic [ADDR_W-1:0]  out_addr_r;
  logic               accept_s;
  logic               last_rd_s;
  logic               start_drain_s;
  logic               load_nxt_s;
  logic               drain_done_s;

  assign accept_s  = (state_r == IDLE) && start;
  // rem_r counts reads still to come after the current one, so in_len = 2^LEN_W-1 fits.
  assign last_rd_s = (state_r == LOAD) && (rem_r == '0);

  // Next-state decode.
  always_comb begin
    state_nxt     = state_r;
    start_drain_s = 1'b0;
    load_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && in_len != '0) begin
          state_nxt  = LOAD;
          load_nxt_s = 1'b1;
        end else if (start) begin
          state_nxt     = DRAIN;
          start_drain_s = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        if (rem_r == '0) begin
          state_nxt     = DRAIN;
          start_drain_s = 1'b1;
        end else begin
          load_nxt_s = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_done_s) begin
          state_nxt = DONE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched config and load-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      rem_r      <= '0;
      out_addr_r <= '0;
    end else begin
      state_r <= state_nxt;
      busy    <= (state_nxt == LOAD) || (state_nxt == DRAIN);
      done    <= (state_nxt == DONE);
      rd_en   <= load_nxt_s;
      if (accept_s) begin
        rd_addr    <= (in_len != '0) ? in_start_addr : '0;
        rem_r      <= in_len - LEN_W'(1);
        out_addr_r <= out_start_addr;
      end else if (state_r == LOAD && !last_rd_s) begin
        rd_addr <= rd_addr + ADDR_W'(1);
        rem_r   <= rem_r - LEN_W'(1);
      end else begin
        rd_addr <= '0;
      end
    end
  end

  sa_drain_seq #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_drain (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_drain   (start_drain_s),
    .load_sa       (load_nxt_s),
    .out_ready     (out_ready),
    .out_base      (out_addr_r),
    .drain_done    (drain_done_s),
    .sa_en         (sa_en),
    .sa_clc        (sa_clc),
    .row_out_valid (row_out_valid),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr)
  );

endmodule

// File: tb/tb_sa_ctrl_param.sv
// Bench for sa_ctrl_param: table-driven and random tiles on an 8x8 instance checked
// against a step-level model, plus a directed wrap-around tile on a 4x4 instance.
module tb_sa_ctrl_param;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start, out_ready, busy, done, rd_en, sa_en, wr_en;
  logic [15:0] in_start_addr, in_len, out_start_addr, rd_addr, wr_addr;
  logic [63:0] sa_clc;
  logic [7:0]  row_out_valid;

  logic        start4, out_ready4, busy4, done4, rd_en4, sa_en4, wr_en4;
  logic [15:0] in_start_addr4, in_len4, out_start_addr4, rd_addr4, wr_addr4;
  logic [15:0] sa_clc4;
  logic [3:0]  row_out_valid4;

  int checks = 0;
  int errors = 0;

  sa_ctrl_param #(.N(8), .ADDR_W(16), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_start_addr(in_start_addr),
    .in_len(in_len), .out_start_addr(out_start_addr), .out_ready(out_ready),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .sa_en(sa_en),
    .sa_clc(sa_clc), .row_out_valid(row_out_valid), .wr_en(wr_en), .wr_addr(wr_addr)
  );

  sa_ctrl_param #(.N(4), .ADDR_W(16), .LEN_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .in_start_addr(in_start_addr4),
    .in_len(in_len4), .out_start_addr(out_start_addr4), .out_ready(out_ready4),
    .busy(busy4), .done(done4), .rd_en(rd_en4), .rd_addr(rd_addr4), .sa_en(sa_en4),
    .sa_clc(sa_clc4), .row_out_valid(row_out_valid4), .wr_en(wr_en4), .wr_addr(wr_addr4)
  );

  typedef struct {
    logic [15:0] ia;
    logic [15:0] len;
    logic [15:0] oa;
    int          pct;
    int          stall_k;
    int          abort_k;
    bit          noise;
    logic [15:0] last_rd;
    logic [15:0] last_wr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // On anti-diagonal k the PEs satisfy r + c = 14 - k.
  function automatic logic [63:0] diag8(input int k);
    logic [63:0] m;
    int c;
    m = '0;
    for (int r = 0; r < 8; r++) begin
      c = 14 - k - r;
      if (c >= 0 && c < 8) m[r*8+c] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [7:0] row8(input int k);
    logic [7:0] one;
    one = 8'd1;
    if (k >= 7 && k <= 14) return one << (14 - k);
    return 8'h00;
  endfunction

  task automatic expect_all(input string tag, input logic b, input logic d, input logic re,
                            input logic [15:0] ra, input logic se, input logic [63:0] m,
                            input logic [7:0] rw, input logic we, input logic [15:0] wa);
    chk({tag, ".busy"}, 64'(busy), 64'(b));
    chk({tag, ".done"}, 64'(done), 64'(d));
    chk({tag, ".rd_en"}, 64'(rd_en), 64'(re));
    chk({tag, ".rd_addr"}, 64'(rd_addr), 64'(ra));
    chk({tag, ".sa_en"}, 64'(sa_en), 64'(se));
    chk({tag, ".sa_clc"}, sa_clc, m);
    chk({tag, ".row"}, 64'(row_out_valid), 64'(rw));
    chk({tag, ".wr_en"}, 64'(wr_en), 64'(we));
    chk({tag, ".wr_addr"}, 64'(wr_addr), 64'(wa));
  endtask

  task automatic drive_noise(input bit en);
    start          = en ? 1'($urandom_range(0, 1)) : 1'b0;
    in_start_addr  = 16'($urandom);
    in_len         = 16'($urandom);
    out_start_addr = 16'($urandom);
  endtask

  task automatic run_tile(input vec_t v);
    int          wr_cnt, budget, stall_left;
    logic [15:0] exp_wa, last_rd_seen, last_wa;
    bit          first, w_exp, r, writing, adv;
    @(negedge clk);
    expect_all("idle", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 64'h0, 8'h0, 1'b0, 16'h0);
    start = 1'b1; in_start_addr = v.ia; in_len = v.len; out_start_addr = v.oa; out_ready = 1'b1;
    @(negedge clk);
    last_rd_seen = 16'h0;
    for (int i = 0; i < int'(v.len); i++) begin
      expect_all("load", 1'b1, 1'b0, 1'b1, v.ia + 16'(i), 1'b1, 64'h0, 8'h0, 1'b0, 16'h0);
      last_rd_seen = rd_addr;
      drive_noise(v.noise);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    if (v.len != 16'h0) chk("last_rd", 64'(last_rd_seen), 64'(v.last_rd));
    stall_left = 3; wr_cnt = 0; exp_wa = v.oa; last_wa = 16'h0;
    for (int k = 0; k < 2 * N; k++) begin
      writing = (k >= N - 1 && k <= 2 * N - 2);
      first = 1'b1; w_exp = writing; budget = 0;
      forever begin
        expect_all("drain", 1'b1, 1'b0, 1'b0, 16'h0, first && (k < 2 * N - 1), diag8(k), row8(k),
                   w_exp, writing ? (v.oa + 16'(k - (N - 1))) : 16'h0);
        if (first && k == v.abort_k) begin
          #2 rst_n = 1'b0;
          #1 expect_all("async_rst", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 64'h0, 8'h0, 1'b0, 16'h0);
          drive_noise(1'b0);
          @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          expect_all("after_rst", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 64'h0, 8'h0, 1'b0, 16'h0);
          return;
        end
        drive_noise(v.noise);
        if (k == v.stall_k && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = ($urandom_range(1, 100) <= v.pct);
        end
        r = out_ready;
        if (wr_en && r) begin
          wr_cnt++;
          chk("wr_order", 64'(wr_addr), 64'(exp_wa));
          last_wa = wr_addr;
          exp_wa = exp_wa + 16'd1;
        end
        adv = !writing || (w_exp && r);
        @(negedge clk);
        if (adv) break;
        w_exp = r; first = 1'b0; budget++;
        if (budget > 300) begin
          chk("stall_bound", 64'(budget), 64'd0);
          break;
        end
      end
    end
    expect_all("done", 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 64'h0, 8'h0, 1'b0, 16'h0);
    chk("wr_count", 64'(wr_cnt), 64'd8);
    chk("last_wr", 64'(last_wa), 64'(v.last_wr));
    start = 1'b1; in_start_addr = 16'($urandom); in_len = 16'd5; out_start_addr = 16'($urandom);
    @(negedge clk);
    expect_all("post_done", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 64'h0, 8'h0, 1'b0, 16'h0);
    start = 1'b0;
  endtask

  task automatic run_n4();
    logic [15:0] rds[3];
    logic [15:0] m4[8];
    logic [3:0]  rows[8];
    rds  = '{16'hFFFE, 16'hFFFF, 16'h0000};
    m4   = '{16'h8000, 16'h4800, 16'h2480, 16'h1248, 16'h0124, 16'h0012, 16'h0001, 16'h0000};
    rows = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h4, 4'h2, 4'h1, 4'h0};
    @(negedge clk);
    start4 = 1'b1; in_start_addr4 = 16'hFFFE; in_len4 = 16'd3; out_start_addr4 = 16'h0020;
    out_ready4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("n4.rd_en", 64'(rd_en4), 64'd1);
      chk("n4.rd_addr", 64'(rd_addr4), 64'(rds[i]));
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++) begin
      chk("n4.rd_en_drain", 64'(rd_en4), 64'd0);
      chk("n4.sa_clc", 64'(sa_clc4), 64'(m4[k]));
      chk("n4.row", 64'(row_out_valid4), 64'(rows[k]));
      chk("n4.wr_en", 64'(wr_en4), (k >= 3 && k <= 6) ? 64'd1 : 64'd0);
      if (k >= 3 && k <= 6) chk("n4.wr_addr", 64'(wr_addr4), 64'(16'h0020 + 16'(k - 3)));
      @(negedge clk);
    end
    chk("n4.done", 64'(done4), 64'd1);
    chk("n4.busy", 64'(busy4), 64'd0);
    @(negedge clk);
    chk("n4.done_pulse", 64'(done4), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    vec_t rv;
    start = 1'b0; in_start_addr = 16'h0; in_len = 16'h0; out_start_addr = 16'h0; out_ready = 1'b0;
    start4 = 1'b0; in_start_addr4 = 16'h0; in_len4 = 16'h0; out_start_addr4 = 16'h0;
    out_ready4 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    expect_all("reset", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 64'h0, 8'h0, 1'b0, 16'h0);
    chk("reset.busy4", 64'(busy4), 64'd0);
    chk("reset.clc4", 64'(sa_clc4), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    tbl[0] = '{16'h0010, 16'd4, 16'h0040, 100, 99, 99, 1'b0, 16'h0013, 16'h0047};
    tbl[1] = '{16'h0100, 16'd0, 16'h0200, 100, 99, 99, 1'b0, 16'h0000, 16'h0207};
    tbl[2] = '{16'h0020, 16'd2, 16'h0040, 100, 9, 99, 1'b0, 16'h0021, 16'h0047};
    tbl[3] = '{16'h1000, 16'd6, 16'hFFFC, 60, 99, 99, 1'b1, 16'h1005, 16'h0003};
    tbl[4] = '{16'h0030, 16'd3, 16'h0050, 100, 99, 10, 1'b0, 16'h0032, 16'h0057};
    tbl[5] = '{16'h0000, 16'd1, 16'h0000, 100, 99, 99, 1'b0, 16'h0000, 16'h0007};
    for (int i = 0; i < 6; i++) run_tile(tbl[i]);

    for (int i = 0; i < 6; i++) begin
      rv.ia = 16'($urandom); rv.len = 16'($urandom_range(0, 12)); rv.oa = 16'($urandom);
      rv.pct = int'($urandom_range(40, 100)); rv.stall_k = 99; rv.abort_k = 99; rv.noise = 1'b1;
      rv.last_rd = rv.ia + rv.len - 16'd1; rv.last_wr = rv.oa + 16'd7;
      run_tile(rv);
    end

    run_n4();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
